// File: rtl/datapath_param.sv
// rtl/datapath_param.sv - parametrised register-file / shifter / ALU datapath
//
// Purpose: NREGS x WIDTH register file with a writeback mux, A/B operand
// registers, a 1-bit shifter on B, a 4-op ALU, a C result register and a
// Z/N/V status register.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   readnum, writenum     register-file read / write index
//   write, vsel           register write enable, writeback source select
//   loada, loadb          load A / B from the read port
//   shift, asel, bsel     shifter op, A-zero select, immediate-B select
//   ALUop, loadc, loads   ALU op, load C, load status flags
//   datapath_in, mdata    immediate and memory writeback data
//   pc, sximm5            program counter, 5-bit signed immediate
//   datapath_out          contents of C
//   Z_out, N_out, V_out   status flags

module datapath_param #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int RW    = $clog2(NREGS),
  parameter int PC_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RW-1:0]    readnum,
  input  logic [RW-1:0]    writenum,
  input  logic             write,
  input  logic [1:0]       vsel,
  input  logic             loada,
  input  logic             loadb,
  input  logic [1:0]       shift,
  input  logic             asel,
  input  logic             bsel,
  input  logic [1:0]       ALUop,
  input  logic             loadc,
  input  logic             loads,
  input  logic [WIDTH-1:0] datapath_in,
  input  logic [WIDTH-1:0] mdata,
  input  logic [PC_W-1:0]  pc,
  input  logic [4:0]       sximm5,
  output logic [WIDTH-1:0] datapath_out,
  output logic             Z_out,
  output logic             N_out,
  output logic             V_out
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] a_q, b_q, c_q;
  logic             z_q, n_q, v_q;

  logic [WIDTH-1:0] wb_data, rd_data, shift_out, sximm, ain, bin, alu_out;
  logic             alu_v;

  // Writeback source; pc is zero-extended.
  always_comb begin
    wb_data = '0;
    case (vsel)
      2'b00:   wb_data = c_q;
      2'b01:   wb_data = datapath_in;
      2'b10:   wb_data[PC_W-1:0] = pc;
      default: wb_data = mdata;
    endcase
  end

  // Combinational read; a same-cycle write is only visible after the edge.
  assign rd_data = regs[readnum];

  always_comb begin
    shift_out = b_q;
    case (shift)
      2'b01:   shift_out = {b_q[MSB-1:0], 1'b0};
      2'b10:   shift_out = {1'b0, b_q[MSB:1]};
      2'b11:   shift_out = {b_q[MSB], b_q[MSB:1]};
      default: shift_out = b_q;
    endcase
  end

  assign sximm = WIDTH'($signed(sximm5));
  assign ain   = asel ? '0 : a_q;
  assign bin   = bsel ? sximm : shift_out;

  always_comb begin
    alu_out = '0;
    alu_v   = 1'b0;
    case (ALUop)
      2'b00: begin
        alu_out = ain + bin;
        alu_v   = (ain[MSB] == bin[MSB]) && (alu_out[MSB] != ain[MSB]);
      end
      2'b01: begin
        alu_out = ain + ~bin + WIDTH'(1);
        alu_v   = (ain[MSB] != bin[MSB]) && (alu_out[MSB] != ain[MSB]);
      end
      2'b10:   alu_out = ain & bin;
      default: alu_out = ~bin;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      z_q <= 1'b0;
      n_q <= 1'b0;
      v_q <= 1'b0;
    end else begin
      if (write) regs[writenum] <= wb_data;
      if (loada) a_q <= rd_data;
      if (loadb) b_q <= rd_data;
      if (loadc) c_q <= alu_out;
      if (loads) begin
        z_q <= (alu_out == '0);
        n_q <= alu_out[MSB];
        v_q <= alu_v;
      end
    end
  end

  assign datapath_out = c_q;
  assign Z_out        = z_q;
  assign N_out        = n_q;
  assign V_out        = v_q;

endmodule

// File: tb/tb_datapath_param.sv
// tb/tb_datapath_param.sv - scoreboard bench for datapath_param at 16-bit/8-reg and 8-bit/4-reg

module tb_datapath_param;

  logic        clk = 1'b0;
  logic        reset, write, loada, loadb, asel, bsel, loadc, loads;
  logic [2:0]  readnum, writenum;
  logic [1:0]  vsel, shift, ALUop;
  logic [15:0] datapath_in, mdata;
  logic [7:0]  pc;
  logic [4:0]  sximm5;
  logic [15:0] dout16;
  logic        z16, n16, v16;
  logic [7:0]  dout8;
  logic        z8, n8, v8;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [1:0]  sh;
    logic [1:0]  alu;
    logic        as;
    logic        bs;
    logic [4:0]  imm;
    logic [15:0] c;
    logic [2:0]  f;
    logic [7:0]  c8;
    logic [2:0]  f8;
    logic        chk8;
    logic        chkf;
  } op_t;

  typedef struct packed {
    logic [15:0] c;
    logic [2:0]  f;
    logic [7:0]  c8;
    logic [2:0]  f8;
    logic        chk8;
    logic        chkf;
  } exp_t;

  exp_t sb[$];

  datapath_param #(.WIDTH(16), .NREGS(8), .PC_W(8)) dut16 (
    .clk(clk), .reset(reset), .readnum(readnum), .writenum(writenum),
    .write(write), .vsel(vsel), .loada(loada), .loadb(loadb), .shift(shift),
    .asel(asel), .bsel(bsel), .ALUop(ALUop), .loadc(loadc), .loads(loads),
    .datapath_in(datapath_in), .mdata(mdata), .pc(pc), .sximm5(sximm5),
    .datapath_out(dout16), .Z_out(z16), .N_out(n16), .V_out(v16)
  );

  datapath_param #(.WIDTH(8), .NREGS(4), .PC_W(8)) dut8 (
    .clk(clk), .reset(reset), .readnum(readnum[1:0]), .writenum(writenum[1:0]),
    .write(write), .vsel(vsel), .loada(loada), .loadb(loadb), .shift(shift),
    .asel(asel), .bsel(bsel), .ALUop(ALUop), .loadc(loadc), .loads(loads),
    .datapath_in(datapath_in[7:0]), .mdata(mdata[7:0]), .pc(pc), .sximm5(sximm5),
    .datapath_out(dout8), .Z_out(z8), .N_out(n8), .V_out(v8)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_src(input logic [2:0] idx, input logic [1:0] vs);
    writenum = idx;
    vsel     = vs;
    write    = 1'b1;
    tick();
    write    = 1'b0;
  endtask

  task automatic wr(input logic [2:0] idx, input logic [15:0] val);
    datapath_in = val;
    wr_src(idx, 2'b01);
  endtask

  // A <- reg[ra]; B <- reg[rb]; C (and status when chkf) <- ALU.
  task automatic do_op(input op_t o);
    readnum = o.ra; loada = 1'b1; tick(); loada = 1'b0;
    readnum = o.rb; loadb = 1'b1; tick(); loadb = 1'b0;
    shift = o.sh; ALUop = o.alu; asel = o.as; bsel = o.bs; sximm5 = o.imm;
    loadc = 1'b1; loads = o.chkf; tick();
    loadc = 1'b0; loads = 1'b0;
  endtask

  task automatic run_table(input string tag, input op_t tbl[$]);
    exp_t e;
    foreach (tbl[i]) begin
      sb.push_back('{tbl[i].c, tbl[i].f, tbl[i].c8, tbl[i].f8, tbl[i].chk8, tbl[i].chkf});
      do_op(tbl[i]);
      e = sb.pop_front();
      checks++;
      if (dout16 !== e.c) begin
        errors++; $display("FAIL %s[%0d] c16 got %h exp %h", tag, i, dout16, e.c);
      end
      if (e.chkf) begin
        checks++;
        if ({z16, n16, v16} !== e.f) begin
          errors++; $display("FAIL %s[%0d] zvn16 got %b exp %b", tag, i, {z16, n16, v16}, e.f);
        end
      end
      if (e.chk8) begin
        checks++;
        if (dout8 !== e.c8) begin
          errors++; $display("FAIL %s[%0d] c8 got %h exp %h", tag, i, dout8, e.c8);
        end
        if (e.chkf) begin
          checks++;
          if ({z8, n8, v8} !== e.f8) begin
            errors++; $display("FAIL %s[%0d] zvn8 got %b exp %b", tag, i, {z8, n8, v8}, e.f8);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    op_t rd[$];
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 8; i++) wr(3'(i), 16'(i + 1) * 16'h1111);
    readnum = 3'd2; loada = 1'b1; loadb = 1'b1; tick(); loada = 1'b0; loadb = 1'b0;
    ALUop = 2'b00; asel = 1'b0; bsel = 1'b0; shift = 2'b00; loadc = 1'b1; loads = 1'b1;
    tick(); loadc = 1'b0; loads = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    checks++;
    if (dout16 !== 16'h0) begin errors++; $display("FAIL reset_out16 got %h exp 0000", dout16); end
    checks++;
    if ({z16, n16, v16} !== 3'b000) begin errors++; $display("FAIL reset_flags16 got %b exp 000", {z16, n16, v16}); end
    checks++;
    if (dout8 !== 8'h0) begin errors++; $display("FAIL reset_out8 got %h exp 00", dout8); end
    // reset wins over a write in the same cycle
    datapath_in = 16'hABCD; vsel = 2'b01; writenum = 3'd5; write = 1'b1; reset = 1'b1;
    tick(); write = 1'b0; reset = 1'b0;
    for (int i = 0; i < 8; i++)
      rd.push_back('{3'd0, 3'(i), 2'b00, 2'b00, 1'b1, 1'b0, 5'd0, 16'h0, 3'b000, 8'h0, 3'b000, 1'b1, 1'b0});
    run_table("reset_read", rd);
    // operand loaded before a reset must not survive it
    wr(3'd1, 16'h0005);
    readnum = 3'd1; loada = 1'b1; tick(); loada = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    ALUop = 2'b00; asel = 1'b0; bsel = 1'b1; sximm5 = 5'd0; loadc = 1'b1; loads = 1'b1;
    tick(); loadc = 1'b0; loads = 1'b0;
    checks++;
    if (dout16 !== 16'h0) begin errors++; $display("FAIL reset_midseq got %h exp 0000", dout16); end
    checks++;
    if ({z16, n16, v16} !== 3'b100) begin errors++; $display("FAIL reset_midseq_flags got %b exp 100", {z16, n16, v16}); end
  endtask

  task automatic test_alu();
    op_t t[$];
    wr(3'd0, 16'd1);
    wr(3'd1, 16'd8);
    t.push_back('{3'd1, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 16'd9,    3'b000, 8'd9,  3'b000, 1'b1, 1'b1});
    t.push_back('{3'd1, 3'd0, 2'b00, 2'b01, 1'b0, 1'b0, 5'd0, 16'd7,    3'b000, 8'd7,  3'b000, 1'b1, 1'b1});
    t.push_back('{3'd1, 3'd0, 2'b00, 2'b10, 1'b0, 1'b0, 5'd0, 16'd0,    3'b100, 8'd0,  3'b100, 1'b1, 1'b1});
    t.push_back('{3'd1, 3'd0, 2'b00, 2'b11, 1'b0, 1'b0, 5'd0, 16'hFFFE, 3'b010, 8'hFE, 3'b010, 1'b1, 1'b1});
    run_table("alu", t);
  endtask

  task automatic test_shift();
    op_t t[$];
    wr(3'd3, 16'h8000);
    t.push_back('{3'd0, 3'd1, 2'b01, 2'b00, 1'b1, 1'b0, 5'd0, 16'h0010, 3'b000, 8'h10, 3'b000, 1'b1, 1'b1});
    t.push_back('{3'd0, 3'd1, 2'b10, 2'b00, 1'b1, 1'b0, 5'd0, 16'h0004, 3'b000, 8'h04, 3'b000, 1'b1, 1'b1});
    t.push_back('{3'd0, 3'd3, 2'b11, 2'b00, 1'b1, 1'b0, 5'd0, 16'hC000, 3'b010, 8'h00, 3'b100, 1'b1, 1'b1});
    t.push_back('{3'd0, 3'd3, 2'b01, 2'b00, 1'b1, 1'b0, 5'd0, 16'h0000, 3'b100, 8'h00, 3'b100, 1'b1, 1'b1});
    run_table("shift", t);
  endtask

  task automatic test_overflow();
    op_t t[$];
    wr(3'd0, 16'h0001);
    wr(3'd4, 16'h7FFF);
    wr(3'd5, 16'h8000);
    wr(3'd6, 16'hFFFF);
    t.push_back('{3'd4, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 16'h8000, 3'b011, 8'h0, 3'b000, 1'b0, 1'b1});
    t.push_back('{3'd5, 3'd0, 2'b00, 2'b01, 1'b0, 1'b0, 5'd0, 16'h7FFF, 3'b001, 8'h0, 3'b000, 1'b0, 1'b1});
    t.push_back('{3'd6, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 16'h0000, 3'b100, 8'h0, 3'b000, 1'b0, 1'b1});
    run_table("ovf", t);
  endtask

  task automatic test_immediate();
    op_t t[$];
    wr(3'd0, 16'h0001);
    pc = 8'hA5;      wr_src(3'd2, 2'b10);
    mdata = 16'h1234; wr_src(3'd3, 2'b11);
    t.push_back('{3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b1, 5'b11100, 16'hFFFD, 3'b010, 8'hFD, 3'b010, 1'b1, 1'b1});
    t.push_back('{3'd0, 3'd2, 2'b00, 2'b00, 1'b1, 1'b0, 5'd0,     16'h00A5, 3'b000, 8'hA5, 3'b000, 1'b1, 1'b0});
    t.push_back('{3'd0, 3'd3, 2'b00, 2'b00, 1'b1, 1'b0, 5'd0,     16'h1234, 3'b000, 8'h34, 3'b000, 1'b1, 1'b0});
    run_table("imm", t);
  endtask

  task automatic test_width8();
    op_t t[$];
    wr(3'd0, 16'h0001);
    wr(3'd2, 16'h007F);
    wr(3'd3, 16'h0080);
    wr(3'd1, 16'h00FF);
    t.push_back('{3'd2, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 16'h0080, 3'b000, 8'h80, 3'b011, 1'b1, 1'b1});
    t.push_back('{3'd3, 3'd0, 2'b00, 2'b01, 1'b0, 1'b0, 5'd0, 16'h007F, 3'b000, 8'h7F, 3'b001, 1'b1, 1'b1});
    t.push_back('{3'd1, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 16'h0100, 3'b000, 8'h00, 3'b100, 1'b1, 1'b1});
    run_table("w8", t);
  endtask

  task automatic test_back_to_back();
    op_t t[$];
    exp_t e;
    wr(3'd4, 16'h0011);
    // write r4 and load B from r4 on the same edge: B takes the old value
    sb.push_back('{16'h0011, 3'b000, 8'h11, 3'b000, 1'b1, 1'b0});
    datapath_in = 16'h0055; vsel = 2'b01; writenum = 3'd4; write = 1'b1;
    readnum = 3'd4; loadb = 1'b1; tick(); write = 1'b0; loadb = 1'b0;
    shift = 2'b00; ALUop = 2'b00; asel = 1'b1; bsel = 1'b0; loadc = 1'b1; tick(); loadc = 1'b0;
    e = sb.pop_front();
    checks++;
    if (dout16 !== e.c) begin errors++; $display("FAIL hazard16 got %h exp %h", dout16, e.c); end
    checks++;
    if (dout8 !== e.c8) begin errors++; $display("FAIL hazard8 got %h exp %h", dout8, e.c8); end
    t.push_back('{3'd0, 3'd4, 2'b00, 2'b00, 1'b1, 1'b0, 5'd0, 16'h0055, 3'b000, 8'h55, 3'b000, 1'b1, 1'b0});
    run_table("after_write", t);
    // C -> r7 writeback, then C must hold across edges without loadc
    wr_src(3'd7, 2'b00);
    readnum = 3'd0; loada = 1'b1; tick(); loadb = 1'b1; tick(); loada = 1'b0; loadb = 1'b0;
    checks++;
    if (dout16 !== 16'h0055) begin errors++; $display("FAIL c_hold got %h exp 0055", dout16); end
    t.delete();
    t.push_back('{3'd0, 3'd7, 2'b00, 2'b00, 1'b1, 1'b0, 5'd0, 16'h0055, 3'b000, 8'h55, 3'b000, 1'b1, 1'b0});
    run_table("wb_c", t);
  endtask

  initial begin
    reset = 1'b0; write = 1'b0; loada = 1'b0; loadb = 1'b0; asel = 1'b0; bsel = 1'b0;
    loadc = 1'b0; loads = 1'b0; readnum = '0; writenum = '0; vsel = '0; shift = '0;
    ALUop = '0; datapath_in = '0; mdata = '0; pc = '0; sximm5 = '0;
    test_reset();
    test_alu();
    test_shift();
    test_overflow();
    test_immediate();
    test_width8();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
